// File: rtl/gemm_tile_sequencer.sv
// Tile-level GEMM controller: loads A/B/C rows from scratchpad, runs the systolic
// array for its fill/compute/drain window, then writes D rows back.
module gemm_tile_sequencer #(
    parameter int unsigned DIM    = 4,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned ROW_W = $clog2(DIM)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic [ADDR_W-1:0] base_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    output logic [1:0]        buf_sel,
    output logic [ROW_W-1:0]  row_idx,
    output logic              array_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CYC_N = 3 * DIM - 2;
    localparam int unsigned CYC_W = $clog2(CYC_N);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [ROW_W-1:0]    row, row_nx;
    logic [CYC_W-1:0]    cyc, cyc_nx;
    logic [ADDR_W-1:0]   ba, bb, bc, bd;
    logic [ADDR_W-1:0]   ba_nx, bb_nx, bc_nx, bd_nx;

    logic                req_nx, we_nx, en_nx, busy_nx, done_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [1:0]          sel_nx;
    logic [ROW_W-1:0]    ridx_nx;
    logic                hs;
    logic                last_row;

    assign hs       = mem_req & mem_ready;
    assign last_row = (row == ROW_W'(DIM - 1));

    // Next state, counters and base latches
    always_comb begin
        state_nx = state;
        row_nx   = row;
        cyc_nx   = cyc;
        ba_nx    = ba;
        bb_nx    = bb;
        bc_nx    = bc;
        bd_nx    = bd;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ba_nx    = base_a;
                    bb_nx    = base_b;
                    bc_nx    = base_c;
                    bd_nx    = base_d;
                    row_nx   = '0;
                    cyc_nx   = '0;
                    state_nx = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B, S_LOAD_C, S_DRAIN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    row_nx   = '0;
                end else if (hs) begin
                    if (last_row) begin
                        row_nx = '0;
                        case (state)
                            S_LOAD_A: state_nx = S_LOAD_B;
                            S_LOAD_B: state_nx = S_LOAD_C;
                            S_LOAD_C: state_nx = S_COMPUTE;
                            default:  state_nx = S_DONE;
                        endcase
                    end else begin
                        row_nx = row + ROW_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    cyc_nx   = '0;
                end else if (cyc == CYC_W'(CYC_N - 1)) begin
                    state_nx = S_DRAIN;
                    cyc_nx   = '0;
                    row_nx   = '0;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded one cycle early so they leave the flops aligned with state
    always_comb begin
        req_nx  = 1'b0;
        we_nx   = 1'b0;
        addr_nx = '0;
        sel_nx  = 2'd3;
        ridx_nx = '0;
        en_nx   = 1'b0;
        busy_nx = (state_nx != S_IDLE);
        done_nx = 1'b0;
        case (state_nx)
            S_LOAD_A: begin
                req_nx  = 1'b1;
                sel_nx  = 2'd0;
                ridx_nx = row_nx;
                addr_nx = ba_nx + ADDR_W'(row_nx);
            end
            S_LOAD_B: begin
                req_nx  = 1'b1;
                sel_nx  = 2'd1;
                ridx_nx = row_nx;
                addr_nx = bb_nx + ADDR_W'(row_nx);
            end
            S_LOAD_C: begin
                req_nx  = 1'b1;
                sel_nx  = 2'd2;
                ridx_nx = row_nx;
                addr_nx = bc_nx + ADDR_W'(row_nx);
            end
            S_COMPUTE: en_nx = 1'b1;
            S_DRAIN: begin
                req_nx  = 1'b1;
                we_nx   = 1'b1;
                ridx_nx = row_nx;
                addr_nx = bd_nx + ADDR_W'(row_nx);
            end
            S_DONE:  done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            row      <= '0;
            cyc      <= '0;
            ba       <= '0;
            bb       <= '0;
            bc       <= '0;
            bd       <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            buf_sel  <= 2'd3;
            row_idx  <= '0;
            array_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            cyc      <= cyc_nx;
            ba       <= ba_nx;
            bb       <= bb_nx;
            bc       <= bc_nx;
            bd       <= bd_nx;
            mem_req  <= req_nx;
            mem_we   <= we_nx;
            mem_addr <= addr_nx;
            buf_sel  <= sel_nx;
            row_idx  <= ridx_nx;
            array_en <= en_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer (DIM=4): cycle-by-cycle output traces
// compared against hand-derived schedules.
module tb_gemm_tile_sequencer;

    logic       CLK = 1'b0;
    logic       RST, start, abort, mem_ready;
    logic [7:0] base_a, base_b, base_c, base_d;
    logic       mem_req, mem_we, array_en, busy, done;
    logic [7:0] mem_addr;
    logic [1:0] buf_sel;
    logic [1:0] row_idx;

    int n_checks = 0;
    int n_fail   = 0;

    gemm_tile_sequencer #(.DIM(4), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .base_a(base_a), .base_b(base_b), .base_c(base_c), .base_d(base_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .buf_sel(buf_sel), .row_idx(row_idx),
        .array_en(array_en), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // {req, we, addr[7:0], buf_sel[1:0], row_idx[1:0], array_en, busy, done}
    function automatic logic [16:0] pk(input logic rq, input logic we, input logic [7:0] ad,
                                       input logic [1:0] bs, input logic [1:0] ri,
                                       input logic en, input logic bz, input logic dn);
        return {rq, we, ad, bs, ri, en, bz, dn};
    endfunction

    function automatic logic [16:0] idle_out();
        return pk(1'b0, 1'b0, 8'h00, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Expected outputs in cycle c after start was sampled, mem_ready held high
    function automatic logic [16:0] nom(input int c, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] cc, input logic [7:0] d);
        if (c >= 1 && c <= 4)
            return pk(1'b1, 1'b0, 8'(a + 8'(c - 1)), 2'd0, 2'(c - 1), 1'b0, 1'b1, 1'b0);
        if (c >= 5 && c <= 8)
            return pk(1'b1, 1'b0, 8'(b + 8'(c - 5)), 2'd1, 2'(c - 5), 1'b0, 1'b1, 1'b0);
        if (c >= 9 && c <= 12)
            return pk(1'b1, 1'b0, 8'(cc + 8'(c - 9)), 2'd2, 2'(c - 9), 1'b0, 1'b1, 1'b0);
        if (c >= 13 && c <= 22)
            return pk(1'b0, 1'b0, 8'h00, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
        if (c >= 23 && c <= 26)
            return pk(1'b1, 1'b1, 8'(d + 8'(c - 23)), 2'd3, 2'(c - 23), 1'b0, 1'b1, 1'b0);
        if (c == 27)
            return pk(1'b0, 1'b0, 8'h00, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1);
        return idle_out();
    endfunction

    function automatic logic [16:0] obs();
        return {mem_req, mem_we, mem_addr, buf_sel, row_idx, array_en, busy, done};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (req,we,addr,sel,row,en,busy,done)",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] cc, input logic [7:0] d);
        base_a = a; base_b = b; base_c = cc; base_d = d;
        start = 1'b1; abort = 1'b0; mem_ready = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full op; optional stall of len cycles starting at cycle s; optional start spam while busy
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] cc, input logic [7:0] d,
                          input int s, input int len, input bit spam);
        int m;
        launch(a, b, cc, d);
        if (spam) begin
            base_a = 8'h55; base_b = 8'h66; base_c = 8'h77; base_d = 8'h88;
        end
        for (int c = 1; c <= 28 + len; c++) begin
            if (c < s)             m = c;
            else if (c <= s + len) m = s;
            else                   m = c - len;
            mem_ready = !(c >= s && c < s + len);
            start     = spam && (c <= 27 + len);
            check($sformatf("%s_c%0d", tag, c), obs(), nom(m, a, b, cc, d));
            step();
        end
        start = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        base_a = 8'h00; base_b = 8'h00; base_c = 8'h00; base_d = 8'h00;
        step();
        step();
        check("reset", obs(), idle_out());
        RST = 1'b0;
        step();
        check("idle_after_reset", obs(), idle_out());

        run_op("nominal", 8'd10, 8'd20, 8'd30, 8'd40, 0, 0, 1'b0);
        run_op("stall", 8'd10, 8'd20, 8'd30, 8'd40, 7, 3, 1'b0);
        run_op("wrap", 8'd10, 8'd20, 8'hFE, 8'd40, 0, 0, 1'b0);

        // abort in COMPUTE cycle 5 (cycle 17 overall)
        launch(8'd10, 8'd20, 8'd30, 8'd40);
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("abort_cmp_c%0d", c), obs(), nom(c, 8'd10, 8'd20, 8'd30, 8'd40));
            if (c == 17) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_cmp_idle%0d", i), obs(), idle_out());
            step();
        end
        run_op("after_abort", 8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 1'b0);

        // RST in DRAIN row 1 (cycle 24)
        launch(8'd10, 8'd20, 8'd30, 8'd40);
        for (int c = 1; c <= 24; c++) begin
            check($sformatf("rst_mid_c%0d", c), obs(), nom(c, 8'd10, 8'd20, 8'd30, 8'd40));
            if (c == 24) RST = 1'b1;
            step();
        end
        RST = 1'b0;
        check("rst_mid_reset", obs(), idle_out());
        step();
        check("rst_mid_idle", obs(), idle_out());

        run_op("start_ignored", 8'd10, 8'd20, 8'd30, 8'd40, 0, 0, 1'b1);

        // abort coinciding with the LOAD_A row 3 handshake
        launch(8'd10, 8'd20, 8'd30, 8'd40);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("abort_hs_c%0d", c), obs(), nom(c, 8'd10, 8'd20, 8'd30, 8'd40));
            if (c == 4) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        check("abort_hs_idle0", obs(), idle_out());
        step();
        check("abort_hs_idle1", obs(), idle_out());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
